// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch port, data port and the memory side.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_done;
  logic            if_err;
  logic [XLEN-1:0] if_rdata;
  logic            if_stall;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_done;
  logic            dm_err;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_stall;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_ready, mem_rdata,
    output if_done, if_err, if_rdata, if_stall,
    output dm_done, dm_err, dm_rdata, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_ready, mem_rdata,
    input  if_done, if_err, if_rdata, if_stall,
    input  dm_done, dm_err, dm_rdata, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data,
// with a per-transaction wait timeout that aborts with an error flag.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_d;
  logic [7:0] wait_cnt;

  logic if_elig;
  logic dm_elig;
  logic grant_i;
  logic grant_d;
  logic busy_d;
  logic expired;
  logic ok;

  // A port whose done is high this cycle is still holding req from
  // the finished transaction and must not be granted again.
  assign if_elig = bus.if_req & ~bus.if_done;
  assign dm_elig = bus.dm_req & ~bus.dm_done;

  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_done;

  assign busy_d  = (state == BUSY_D);
  assign expired = (wait_cnt == LAST_WAIT);
  assign ok      = bus.mem_ready;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (1'b1)
      (if_elig & dm_elig): begin
        grant_i = last_d;
        grant_d = ~last_d;
      end
      (if_elig & ~dm_elig): grant_i = 1'b1;
      (~if_elig & dm_elig): grant_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      wait_cnt      <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_done   <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_done   <= 1'b0;
      bus.dm_err    <= 1'b0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.dm_done <= 1'b0;
      bus.dm_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_i | grant_d) begin
            state         <= grant_d ? BUSY_D : BUSY_I;
            last_d        <= grant_d;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= grant_d & bus.dm_we;
            bus.mem_addr  <= grant_d ? bus.dm_addr : bus.if_addr;
            bus.mem_wdata <= grant_d ? bus.dm_wdata : XLEN'(0);
          end
        end
        BUSY_I, BUSY_D: begin
          // Ready on the last allowed wait cycle still completes normally.
          if (ok | expired) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (busy_d) begin
              bus.dm_done <= 1'b1;
              bus.dm_err  <= ~ok;
              if (!ok)
                bus.dm_rdata <= XLEN'(0);
              else if (!bus.mem_we)
                bus.dm_rdata <= bus.mem_rdata;
            end else begin
              bus.if_done  <= 1'b1;
              bus.if_err   <= ~ok;
              bus.if_rdata <= ok ? bus.mem_rdata : XLEN'(0);
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of arbitration, timing, timeout and reset, followed by
// random traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(
    .XLEN   (XLEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_wait_case(input string tag, input int ready_at,
                              input logic [31:0] data, input logic exp_err,
                              input logic [31:0] exp_rd);
    cyc();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h80;
    for (int c = 1; c <= TIMEOUT; c++) begin
      cyc();
      bus.mem_ready = (c == ready_at);
      bus.mem_rdata = data;
      @(negedge clk);
      chk({tag, "_mreq"}, bus.mem_req, 1);
      chk({tag, "_nodone"}, bus.dm_done, 0);
    end
    cyc();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, bus.dm_done, 1);
    chk({tag, "_err"}, bus.dm_err, exp_err);
    chk({tag, "_rdata"}, bus.dm_rdata, exp_rd);
    chk({tag, "_mreq_off"}, bus.mem_req, 0);
    cyc();
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, bus.dm_done, 0);
  endtask

  // reference model state
  bit          m_busy;
  bit          m_d;
  bit          m_we;
  int          m_k;
  int          m_delay;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          last_d;
  bit          e_if_done, e_dm_done, e_if_err, e_dm_err;
  bit          n_if_done, n_dm_done, n_if_err, n_dm_err;
  logic [31:0] e_if_rdata, e_dm_rdata;
  bit          drop_i, drop_d, el_i, el_d;
  int          n;

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_done", bus.if_done, 0);
    chk("rst_dm_done", bus.dm_done, 0);
    chk("rst_if_err", bus.if_err, 0);
    chk("rst_dm_err", bus.dm_err, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);

    // fetch alone, zero-wait memory
    cyc();
    rst         = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    @(negedge clk);
    chk("f_stall0", bus.if_stall, 1);
    chk("f_mreq0", bus.mem_req, 0);
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00500093;
    @(negedge clk);
    chk("f_mreq1", bus.mem_req, 1);
    chk("f_maddr1", bus.mem_addr, 32'h100);
    chk("f_mwe1", bus.mem_we, 0);
    chk("f_mwdata1", bus.mem_wdata, 0);
    cyc();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("f_done2", bus.if_done, 1);
    chk("f_err2", bus.if_err, 0);
    chk("f_rdata2", bus.if_rdata, 32'h00500093);
    chk("f_mreq2", bus.mem_req, 0);
    chk("f_stall2", bus.if_stall, 0);
    cyc();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("f_done3", bus.if_done, 0);
    chk("f_mreq3", bus.mem_req, 0);

    // data write with three wait cycles
    cyc();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("w_stall0", bus.dm_stall, 1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      bus.mem_ready = (c == 4);
      bus.mem_rdata = 32'h12345678;
      @(negedge clk);
      chk("w_mreq", bus.mem_req, 1);
      chk("w_mwe", bus.mem_we, 1);
      chk("w_maddr", bus.mem_addr, 32'h40);
      chk("w_mwdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("w_stall", bus.dm_stall, 1);
      chk("w_nodone", bus.dm_done, 0);
    end
    cyc();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("w_done5", bus.dm_done, 1);
    chk("w_err5", bus.dm_err, 0);
    chk("w_rdata5", bus.dm_rdata, 0);
    chk("w_stall5", bus.dm_stall, 0);
    chk("w_mreq5", bus.mem_req, 0);
    chk("w_mwe5", bus.mem_we, 0);
    cyc();
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;

    // ready on the last wait cycle, then no ready at all
    dm_wait_case("to_edge", TIMEOUT, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
    dm_wait_case("to_abort", 0, 32'h55AA55AA, 1'b1, 32'h0);

    // reset in the middle of a waiting fetch
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    cyc();
    @(negedge clk);
    chk("r_mreq1", bus.mem_req, 1);
    cyc();
    rst        = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("r_mreq2", bus.mem_req, 1);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("r_mreq3", bus.mem_req, 0);
    chk("r_done3", bus.if_done, 0);
    chk("r_maddr3", bus.mem_addr, 0);
    chk("r_mwe3", bus.mem_we, 0);
    chk("r_ifrd3", bus.if_rdata, 0);
    chk("r_dmrd3", bus.dm_rdata, 0);
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD0000;
    @(negedge clk);
    chk("r_mreq4", bus.mem_req, 0);
    cyc();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("r_done5", bus.if_done, 0);
    chk("r_ifrd5", bus.if_rdata, 0);
    chk("r_dmdone5", bus.dm_done, 0);

    // both ports held after reset: grants alternate starting with fetch
    cyc();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h300;
    bus.dm_req    = 1'b1;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h400;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      @(negedge clk);
      if (bus.mem_req) begin
        chk($sformatf("rr_grant%0d", n), bus.mem_addr,
            (n % 2 == 0) ? 32'h300 : 32'h400);
        n++;
      end
      chk("rr_not_both", {31'b0, bus.if_done & bus.dm_done}, 0);
    end
    chk("rr_count", n, 8);
    cyc();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (3) cyc();
    bus.mem_ready = 1'b0;

    // random traffic against the reference model
    rst = 1'b1;
    cyc();
    m_busy     = 0;
    last_d     = 1;
    e_if_done  = 0;
    e_dm_done  = 0;
    e_if_err   = 0;
    e_dm_err   = 0;
    e_if_rdata = '0;
    e_dm_rdata = '0;
    drop_i     = 0;
    drop_d     = 0;
    for (int t = 0; t < 3000; t++) begin
      cyc();
      rst = 1'b0;
      if (drop_i) begin
        bus.if_req = 1'b0;
        drop_i     = 0;
      end else if (!bus.if_req && $urandom_range(2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      if (drop_d) begin
        bus.dm_req = 1'b0;
        drop_d     = 0;
      end else if (!bus.dm_req && $urandom_range(2) == 0) begin
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'($urandom_range(1));
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
      end
      bus.mem_rdata = $urandom;
      if (m_busy)
        bus.mem_ready = (m_k == m_delay);
      else
        bus.mem_ready = ($urandom_range(3) == 0);
      @(negedge clk);

      chk("m_mem_req", bus.mem_req, m_busy);
      if (m_busy) begin
        chk("m_mem_addr", bus.mem_addr, m_addr);
        chk("m_mem_we", bus.mem_we, m_we);
        chk("m_mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("m_if_done", bus.if_done, e_if_done);
      chk("m_dm_done", bus.dm_done, e_dm_done);
      if (e_if_done) chk("m_if_err", bus.if_err, e_if_err);
      if (e_dm_done) chk("m_dm_err", bus.dm_err, e_dm_err);
      chk("m_if_rdata", bus.if_rdata, e_if_rdata);
      chk("m_dm_rdata", bus.dm_rdata, e_dm_rdata);
      chk("m_if_stall", bus.if_stall, bus.if_req & ~e_if_done);
      chk("m_dm_stall", bus.dm_stall, bus.dm_req & ~e_dm_done);
      if (bus.if_done) drop_i = 1;
      if (bus.dm_done) drop_d = 1;

      n_if_done = 0;
      n_dm_done = 0;
      n_if_err  = 0;
      n_dm_err  = 0;
      if (m_busy) begin
        if (bus.mem_ready || m_k + 1 == TIMEOUT) begin
          if (m_d) begin
            n_dm_done = 1;
            n_dm_err  = !bus.mem_ready;
            if (!bus.mem_ready) e_dm_rdata = '0;
            else if (!m_we) e_dm_rdata = bus.mem_rdata;
          end else begin
            n_if_done  = 1;
            n_if_err   = !bus.mem_ready;
            e_if_rdata = bus.mem_ready ? bus.mem_rdata : 32'h0;
          end
          m_busy = 0;
        end else begin
          m_k++;
        end
      end else begin
        el_i = bus.if_req && !e_if_done;
        el_d = bus.dm_req && !e_dm_done;
        if (el_i || el_d) begin
          m_d     = el_d && (!el_i || !last_d);
          last_d  = m_d;
          m_busy  = 1;
          m_k     = 0;
          m_addr  = m_d ? bus.dm_addr : bus.if_addr;
          m_we    = m_d && bus.dm_we;
          m_wdata = m_d ? bus.dm_wdata : 32'h0;
          if ($urandom_range(4) == 0)
            m_delay = $urandom_range(TIMEOUT + 3, TIMEOUT - 3);
          else
            m_delay = $urandom_range(3);
        end
      end
      e_if_done = n_if_done;
      e_dm_done = n_dm_done;
      e_if_err  = n_if_err;
      e_dm_err  = n_dm_err;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
